// File: rtl/wave_gen_pkg.sv
// Shared types and helpers for the NCO tone generator: wave mode encoding,
// mode sequencing and the one-hot LED mapping.
package wave_gen_pkg;

  // mode        | meaning
  // MODE_SQUARE | two-level square wave (also the decode for illegal 2'd3)
  // MODE_SAW    | rising sawtooth from the phase MSBs
  // MODE_TRI    | folded phase, symmetric triangle
  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_SQUARE: return MODE_SAW;
      MODE_SAW:    return MODE_TRI;
      default:     return MODE_SQUARE;
    endcase
  endfunction

  function automatic logic [2:0] mode_leds(input mode_t m);
    case (m)
      MODE_SAW: return 3'b010;
      MODE_TRI: return 3'b100;
      default:  return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/wave_gen_nco_shaper.sv
// Combinational phase-to-code shaper: square, sawtooth or triangle from the
// accumulator phase.
module wave_shaper
  import wave_gen_pkg::*;
#(
  parameter int CODE_WIDTH = 10,
  parameter int ACC_WIDTH  = 24,
  parameter int SQ_LOW     = 462,
  parameter int SQ_HIGH    = 562
) (
  input  logic [ACC_WIDTH-1:0]  phase,
  input  mode_t                 mode,
  output logic [CODE_WIDTH-1:0] code
);

  localparam logic [CODE_WIDTH-1:0] SQ_LOW_C  = CODE_WIDTH'(SQ_LOW);
  localparam logic [CODE_WIDTH-1:0] SQ_HIGH_C = CODE_WIDTH'(SQ_HIGH);

  logic                  msb;
  logic [CODE_WIDTH-1:0] tri_t;

  assign msb   = phase[ACC_WIDTH-1];
  assign tri_t = phase[ACC_WIDTH-2 -: CODE_WIDTH];

  always_comb begin
    code = msb ? SQ_LOW_C : SQ_HIGH_C;
    case (mode)
      MODE_SAW: code = phase[ACC_WIDTH-1 -: CODE_WIDTH];
      MODE_TRI: code = msb ? ~tri_t : tri_t;
      default:  code = msb ? SQ_LOW_C : SQ_HIGH_C;
    endcase
  end

endmodule

// File: rtl/wave_gen_nco.sv
// NCO tone generator: phase accumulator stepped on next_sample, button-driven
// FCW adjust with clamping, mode/step selection and a registered output code.
module wave_gen_nco
  import wave_gen_pkg::*;
#(
  parameter int CODE_WIDTH  = 10,
  parameter int ACC_WIDTH   = 24,
  parameter int FCW_INIT    = 60473,
  parameter int STEP_COARSE = 1024,
  parameter int STEP_FINE   = 16,
  parameter int FCW_MIN     = 16,
  parameter int FCW_MAX     = 2**(ACC_WIDTH-1)-1,
  parameter int SQ_LOW      = 462,
  parameter int SQ_HIGH     = 562
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  next_sample,
  input  logic [3:0]            buttons,
  output logic [CODE_WIDTH-1:0] code,
  output logic [3:0]            leds,
  output logic [ACC_WIDTH-1:0]  fcw
);

  localparam logic [ACC_WIDTH:0]    STEP_C_W   = (ACC_WIDTH+1)'(STEP_COARSE);
  localparam logic [ACC_WIDTH:0]    STEP_F_W   = (ACC_WIDTH+1)'(STEP_FINE);
  localparam logic [ACC_WIDTH:0]    FCW_MIN_W  = (ACC_WIDTH+1)'(FCW_MIN);
  localparam logic [ACC_WIDTH:0]    FCW_MAX_W  = (ACC_WIDTH+1)'(FCW_MAX);
  localparam logic [ACC_WIDTH-1:0]  FCW_MIN_A  = ACC_WIDTH'(FCW_MIN);
  localparam logic [ACC_WIDTH-1:0]  FCW_MAX_A  = ACC_WIDTH'(FCW_MAX);
  localparam logic [ACC_WIDTH-1:0]  FCW_INIT_A = ACC_WIDTH'(FCW_INIT);
  localparam logic [CODE_WIDTH-1:0] SQ_LOW_C   = CODE_WIDTH'(SQ_LOW);

  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [ACC_WIDTH-1:0]  fcw_next;
  logic [ACC_WIDTH-1:0]  dn_diff;
  logic [ACC_WIDTH:0]    step_w;
  logic [ACC_WIDTH:0]    fcw_ext;
  logic [ACC_WIDTH:0]    up_sum;
  logic [CODE_WIDTH-1:0] shaped;
  mode_t                 mode;
  logic                  fine;

  assign acc_next = acc + fcw;

  wave_shaper #(
    .CODE_WIDTH (CODE_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SQ_LOW     (SQ_LOW),
    .SQ_HIGH    (SQ_HIGH)
  ) u_shaper (
    .phase (acc_next),
    .mode  (mode),
    .code  (shaped)
  );

  // Up/down arithmetic carries an extra bit so clamping is decided before any wrap.
  always_comb begin
    step_w   = fine ? STEP_F_W : STEP_C_W;
    fcw_ext  = {1'b0, fcw};
    up_sum   = fcw_ext + step_w;
    dn_diff  = fcw - step_w[ACC_WIDTH-1:0];
    fcw_next = fcw;
    if (buttons[0] && !buttons[1]) begin
      fcw_next = (up_sum > FCW_MAX_W) ? FCW_MAX_A : up_sum[ACC_WIDTH-1:0];
    end else if (buttons[1] && !buttons[0]) begin
      fcw_next = (fcw_ext < FCW_MIN_W + step_w) ? FCW_MIN_A : dn_diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      fcw  <= FCW_INIT_A;
      mode <= MODE_SQUARE;
      fine <= 1'b0;
      code <= SQ_LOW_C;
    end else begin
      if (next_sample) begin
        acc  <= acc_next;
        code <= shaped;
      end
      fcw <= fcw_next;
      if (buttons[2]) mode <= next_mode(mode);
      if (buttons[3]) fine <= ~fine;
    end
  end

  assign leds = {fine, mode_leds(mode)};

endmodule

// File: tb/tb_wave_gen_nco.sv
// Directed, table-driven bench for wave_gen_nco using four parameterisations.
module tb_wave_gen_nco;

  typedef struct {
    logic       ns;
    logic [3:0] b;
    int         code;
    int         leds;
    int         fcw;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut0: default parameters
  logic ns0 = 1'b0; logic [3:0] b0 = 4'd0;
  logic [9:0] code0; logic [3:0] leds0; logic [23:0] fcw0;
  // dut1: narrow shape check
  logic ns1 = 1'b0; logic [3:0] b1 = 4'd0;
  logic [3:0] code1; logic [3:0] leds1; logic [11:0] fcw1;
  // dut2: high clamp
  logic ns2 = 1'b0; logic [3:0] b2 = 4'd0;
  logic [9:0] code2; logic [3:0] leds2; logic [23:0] fcw2;
  // dut3: low clamp, modes, mid-stream reset
  logic ns3 = 1'b0; logic [3:0] b3 = 4'd0;
  logic [9:0] code3; logic [3:0] leds3; logic [23:0] fcw3;

  wave_gen_nco dut0 (.clk(clk), .rst(rst), .next_sample(ns0), .buttons(b0),
                     .code(code0), .leds(leds0), .fcw(fcw0));

  wave_gen_nco #(.CODE_WIDTH(4), .ACC_WIDTH(12), .FCW_INIT(256),
                 .SQ_LOW(4), .SQ_HIGH(11))
    dut1 (.clk(clk), .rst(rst), .next_sample(ns1), .buttons(b1),
          .code(code1), .leds(leds1), .fcw(fcw1));

  wave_gen_nco #(.FCW_INIT(8388507))
    dut2 (.clk(clk), .rst(rst), .next_sample(ns2), .buttons(b2),
          .code(code2), .leds(leds2), .fcw(fcw2));

  wave_gen_nco #(.FCW_INIT(20))
    dut3 (.clk(clk), .rst(rst), .next_sample(ns3), .buttons(b3),
          .code(code3), .leds(leds3), .fcw(fcw3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  vec_t tab1[34];
  vec_t tab3[17];
  int   saw_exp[16] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0};
  int   tri_exp[16] = '{2,4,6,8,10,12,14,15,13,11,9,7,5,3,1,0};
  int   n;
  bit   done;

  initial begin
    // dut1 table: mode to sawtooth, 16 strobes, mode to triangle, 16 strobes
    tab1[0] = '{1'b0, 4'b0100, 4, 4'b0010, 256};
    for (int i = 0; i < 16; i++) tab1[1+i] = '{1'b1, 4'b0000, saw_exp[i], 4'b0010, 256};
    tab1[17] = '{1'b0, 4'b0100, 0, 4'b0100, 256};
    for (int i = 0; i < 16; i++) tab1[18+i] = '{1'b1, 4'b0000, tri_exp[i], 4'b0100, 256};

    // dut3 table: mode cycling, fine clamp low, coincident strobe/button
    tab3[0]  = '{1'b0, 4'b0100, 462, 4'b0010, 20};
    tab3[1]  = '{1'b0, 4'b0100, 462, 4'b0100, 20};
    tab3[2]  = '{1'b0, 4'b0100, 462, 4'b0001, 20};
    tab3[3]  = '{1'b0, 4'b1000, 462, 4'b1001, 20};
    tab3[4]  = '{1'b0, 4'b0010, 462, 4'b1001, 16};
    tab3[5]  = '{1'b0, 4'b0010, 462, 4'b1001, 16};
    tab3[6]  = '{1'b0, 4'b0011, 462, 4'b1001, 16};
    tab3[7]  = '{1'b0, 4'b0001, 462, 4'b1001, 32};
    tab3[8]  = '{1'b0, 4'b0011, 462, 4'b1001, 32};
    tab3[9]  = '{1'b1, 4'b0000, 562, 4'b1001, 32};
    tab3[10] = '{1'b0, 4'b0100, 562, 4'b1010, 32};
    tab3[11] = '{1'b1, 4'b0001, 0,   4'b1010, 48};
    tab3[12] = '{1'b1, 4'b0000, 0,   4'b1010, 48};
    tab3[13] = '{1'b0, 4'b1000, 0,   4'b0010, 48};
    tab3[14] = '{1'b0, 4'b0001, 0,   4'b0010, 1072};
    tab3[15] = '{1'b0, 4'b0010, 0,   4'b0010, 48};
    tab3[16] = '{1'b0, 4'b0010, 0,   4'b0010, 16};

    #1;
    rst = 1'b1; tick(); tick(); rst = 1'b0;

    check("rst_code0", int'(code0), 462);
    check("rst_leds0", int'(leds0), 1);
    check("rst_fcw0",  int'(fcw0),  60473);
    check("rst_code1", int'(code1), 4);
    check("rst_fcw3",  int'(fcw3),  20);

    // Square: first strobe is high, MSB sets on strobe 139
    ns0 = 1'b1; tick(); ns0 = 1'b0;
    check("sq_first", int'(code0), 562);
    n = 1; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      ns0 = 1'b1; tick(); ns0 = 1'b0;
      n++;
      if (code0 == 10'd462) done = 1'b1;
    end
    check("sq_half_period", n, 139);
    check("sq_low", int'(code0), 462);

    for (int i = 0; i < 34; i++) begin
      ns1 = tab1[i].ns; b1 = tab1[i].b;
      tick();
      ns1 = 1'b0; b1 = 4'd0;
      check($sformatf("shape_code[%0d]", i), int'(code1), tab1[i].code);
      check($sformatf("shape_leds[%0d]", i), int'(leds1), tab1[i].leds);
      check($sformatf("shape_fcw[%0d]", i),  int'(fcw1),  tab1[i].fcw);
    end

    // High clamp, coarse
    b2 = 4'b0001; tick(); b2 = 4'd0;
    check("clamp_hi_1", int'(fcw2), 8388607);
    b2 = 4'b0001; tick(); b2 = 4'd0;
    check("clamp_hi_2", int'(fcw2), 8388607);
    b2 = 4'b0010; tick(); b2 = 4'd0;
    check("coarse_down", int'(fcw2), 8387583);

    for (int i = 0; i < 17; i++) begin
      ns3 = tab3[i].ns; b3 = tab3[i].b;
      tick();
      ns3 = 1'b0; b3 = 4'd0;
      check($sformatf("ctl_code[%0d]", i), int'(code3), tab3[i].code);
      check($sformatf("ctl_leds[%0d]", i), int'(leds3), tab3[i].leds);
      check($sformatf("ctl_fcw[%0d]", i),  int'(fcw3),  tab3[i].fcw);
    end

    // Mid-stream reset: triangle + fine, fcw modified, rst coincident with a strobe
    b3 = 4'b1100; tick(); b3 = 4'd0;
    check("pre_rst_leds", int'(leds3), 4'b1100);
    b3 = 4'b0001; tick(); b3 = 4'd0;
    check("pre_rst_fcw", int'(fcw3), 32);
    ns3 = 1'b1; tick(); tick(); ns3 = 1'b0;
    rst = 1'b1; ns3 = 1'b1; b3 = 4'b0101; tick();
    rst = 1'b0; ns3 = 1'b0; b3 = 4'd0;
    check("rst_mid_code", int'(code3), 462);
    check("rst_mid_leds", int'(leds3), 1);
    check("rst_mid_fcw",  int'(fcw3),  20);
    ns3 = 1'b1; tick(); ns3 = 1'b0;
    check("rst_mid_acc", int'(code3), 562);
    ns3 = 1'b1; b3 = 4'b0100; tick(); ns3 = 1'b0; b3 = 4'd0;
    check("mode_lag_code", int'(code3), 562);
    check("mode_lag_leds", int'(leds3), 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
